// File: rtl/issue_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module : issue_scoreboard_pkg
//  Brief  : Shared widths and FSM encoding for the in-order issue scoreboard.
//  Rev    : 1.0
// ============================================================================
package issue_scoreboard_pkg;

    localparam int LEN_REG_ADDR = 6;
    localparam int LEN_SB_CNT   = 7;
    localparam int SB_NREG      = 2 ** LEN_REG_ADDR;

    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard_sb_hazard.sv
`default_nettype none
// ============================================================================
//  Module : sb_hazard
//  Brief  : Busy lookup with same-cycle writeback bypass and hazard detection.
//  Rev    : 1.0
// ============================================================================
module sb_hazard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG
) (
    input  logic [NREG-1:0]         busy,
    input  logic                    wb0_valid,
    input  logic [LEN_REG_ADDR-1:0] wb0_addr,
    input  logic                    wb1_valid,
    input  logic [LEN_REG_ADDR-1:0] wb1_addr,
    input  logic [LEN_REG_ADDR-1:0] rs1,
    input  logic [LEN_REG_ADDR-1:0] rs2,
    input  logic [LEN_REG_ADDR-1:0] rd,
    output logic [NREG-1:0]         eff_busy,
    output logic                    hazard
);

    genvar i;
    generate
        for (i = 0; i < NREG; i++) begin : g_eff
            localparam logic [LEN_REG_ADDR-1:0] C_IDX = LEN_REG_ADDR'(i);
            assign eff_busy[i] = busy[i]
                               & ~(wb0_valid & (wb0_addr == C_IDX))
                               & ~(wb1_valid & (wb1_addr == C_IDX));
        end
    endgenerate

    // Address 0 means "unused" and never creates a dependency.
    assign hazard = ((rs1 != '0) & eff_busy[rs1])
                  | ((rs2 != '0) & eff_busy[rs2])
                  | ((rd  != '0) & eff_busy[rd]);

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module : issue_scoreboard
//  Brief  : In-order issue controller: busy table, in-flight count, drain FSM.
//  Rev    : 1.0
// ============================================================================
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = LEN_SB_CNT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [LEN_REG_ADDR-1:0] dec_a_rs1,
    input  logic [LEN_REG_ADDR-1:0] dec_a_rs2,
    input  logic [LEN_REG_ADDR-1:0] dec_a_rd,
    input  logic                    dec_long,
    input  logic                    dec_serial,
    input  logic                    long_busy,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    input  logic                    wb0_valid,
    input  logic [LEN_REG_ADDR-1:0] wb0_addr,
    input  logic                    wb1_valid,
    input  logic [LEN_REG_ADDR-1:0] wb1_addr,
    input  logic                    flush,
    output logic [CNT_W-1:0]        inflight,
    output logic                    idle,
    output logic                    sb_err
);

    logic [NREG-1:0]  r_busy;
    logic [NREG-1:0]  w_busy_next;
    logic [NREG-1:0]  w_eff_busy;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] w_cnt_after_clr;
    logic             r_sb_err;
    sb_state_e        r_state;
    sb_state_e        w_state_next;

    logic w_hazard, w_stall, w_fire, w_set;
    logic w_wb0_hit, w_wb1_hit, w_err;

    sb_hazard #(.NREG(NREG)) u_hazard (
        .busy      (r_busy),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .rs1       (dec_a_rs1),
        .rs2       (dec_a_rs2),
        .rd        (dec_a_rd),
        .eff_busy  (w_eff_busy),
        .hazard    (w_hazard)
    );

    // Dual writeback to one register counts as a single clear.
    assign w_wb0_hit = wb0_valid & (wb0_addr != '0) & r_busy[wb0_addr];
    assign w_wb1_hit = wb1_valid & (wb1_addr != '0) & r_busy[wb1_addr]
                     & ~(w_wb0_hit & (wb0_addr == wb1_addr));

    assign w_err = (wb0_valid & (wb0_addr != '0) & ~r_busy[wb0_addr])
                 | (wb1_valid & (wb1_addr != '0) & ~r_busy[wb1_addr])
                 | (wb0_valid & wb1_valid & (wb0_addr != '0) & (wb0_addr == wb1_addr));

    assign w_cnt_after_clr = r_inflight - CNT_W'(w_wb0_hit) - CNT_W'(w_wb1_hit);

    assign w_stall = w_hazard
                   | (dec_long & long_busy)
                   | flush
                   | (r_state != SB_RUN)
                   | (dec_serial & (w_cnt_after_clr != '0));

    assign issue_valid = rstn & dec_valid & ~w_stall;
    assign w_fire      = issue_valid & issue_ready;
    assign dec_ready   = w_fire;
    assign w_set       = w_fire & (dec_a_rd != '0);

    // Set is applied last so a same-cycle re-issue keeps the register busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wb0_hit) w_busy_next[wb0_addr] = 1'b0;
        if (w_wb1_hit) w_busy_next[wb1_addr] = 1'b0;
        if (w_set)     w_busy_next[dec_a_rd] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SB_RUN: begin
                if (dec_valid & dec_serial & ~flush & (w_cnt_after_clr != '0))
                    w_state_next = SB_DRAIN;
            end
            SB_DRAIN: begin
                if ((w_cnt_after_clr == '0) | flush)
                    w_state_next = SB_RUN;
            end
            default: w_state_next = SB_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy     <= '0;
            r_inflight <= '0;
            r_state    <= SB_RUN;
            r_sb_err   <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_inflight <= w_cnt_after_clr + CNT_W'(w_set);
            r_state    <= w_state_next;
            if (w_err) r_sb_err <= 1'b1;
        end
    end

    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0) & (r_state == SB_RUN);
    assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module : tb_issue_scoreboard
//  Brief  : Vector table plus hand sequences for the issue scoreboard.
//  Rev    : 1.0
// ============================================================================
module tb_issue_scoreboard;

    localparam int NREG = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       dec_valid, dec_ready;
    logic [5:0] dec_a_rs1, dec_a_rs2, dec_a_rd;
    logic       dec_long, dec_serial, long_busy;
    logic       issue_valid, issue_ready;
    logic       wb0_valid, wb1_valid;
    logic [5:0] wb0_addr, wb1_addr;
    logic       flush;
    logic [6:0] inflight;
    logic       idle, sb_err;

    issue_scoreboard dut (
        .clk(clk), .rstn(rstn),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_a_rs1(dec_a_rs1), .dec_a_rs2(dec_a_rs2), .dec_a_rd(dec_a_rd),
        .dec_long(dec_long), .dec_serial(dec_serial), .long_busy(long_busy),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr),
        .flush(flush), .inflight(inflight), .idle(idle), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [5:0] rs1, rs2, rd;
        logic       lng, ser, lb, ir;
        logic       w0v;
        logic [5:0] w0a;
        logic       w1v;
        logic [5:0] w1a;
        logic       fl;
        logic       e_iv, e_idle, e_err;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_q[$];
    logic [63:0] mb;

    function automatic vec_t mk(input logic dv, input logic [5:0] rs1, rs2, rd,
                                input logic lng, ser, lb, ir,
                                input logic w0v, input logic [5:0] w0a,
                                input logic w1v, input logic [5:0] w1a,
                                input logic fl, input logic iv, idl, err);
        vec_t v;
        v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.lng = lng; v.ser = ser; v.lb = lb; v.ir = ir;
        v.w0v = w0v; v.w0a = w0a; v.w1v = w1v; v.w1a = w1a; v.fl = fl;
        v.e_iv = iv; v.e_idle = idl; v.e_err = err;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive, check combinational issue, update model, check registered state.
    task automatic apply(input vec_t v, input string tag);
        logic c0, c1;
        int   got;
        dec_valid = v.dv; dec_a_rs1 = v.rs1; dec_a_rs2 = v.rs2; dec_a_rd = v.rd;
        dec_long = v.lng; dec_serial = v.ser; long_busy = v.lb; issue_ready = v.ir;
        wb0_valid = v.w0v; wb0_addr = v.w0a; wb1_valid = v.w1v; wb1_addr = v.w1a;
        flush = v.fl;
        #3;
        check({tag, ".issue_valid"}, int'(issue_valid), int'(v.e_iv));
        check({tag, ".dec_ready"}, int'(dec_ready), int'(v.e_iv & v.ir));
        c0 = v.w0v && (v.w0a != 0) && mb[v.w0a];
        c1 = v.w1v && (v.w1a != 0) && mb[v.w1a] && !(c0 && (v.w1a == v.w0a));
        if (c0) mb[v.w0a] = 1'b0;
        if (c1) mb[v.w1a] = 1'b0;
        if (v.e_iv && v.ir && (v.rd != 0)) mb[v.rd] = 1'b1;
        exp_q.push_back($countones(mb));
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".inflight"}, int'(inflight), got);
        check({tag, ".inflight_max"}, int'(inflight <= 7'(NREG)), 1);
        check({tag, ".idle"}, int'(idle), int'(v.e_idle));
        check({tag, ".sb_err"}, int'(sb_err), int'(v.e_err));
    endtask

    vec_t tbl[18];
    vec_t seq[15];

    initial begin
        mb = '0;
        rstn = 1'b0;
        dec_valid = 0; dec_a_rs1 = 0; dec_a_rs2 = 0; dec_a_rd = 0;
        dec_long = 0; dec_serial = 0; long_busy = 0; issue_ready = 1;
        wb0_valid = 0; wb0_addr = 0; wb1_valid = 0; wb1_addr = 0; flush = 0;

        //            dv rs1   rs2   rd    lg sr lb ir w0v w0a  w1v w1a   fl iv idl err
        tbl[0]  = mk(1, 0,    0,    5,    0, 0, 0, 1, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[1]  = mk(1, 5,    0,    0,    0, 0, 0, 1, 0, 0,    0, 0,    0, 0, 0, 0);
        tbl[2]  = mk(1, 5,    0,    0,    0, 0, 0, 1, 1, 5,    0, 0,    0, 1, 1, 0);
        tbl[3]  = mk(1, 0,    0,    6'h21,0, 0, 0, 1, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[4]  = mk(1, 1,    0,    2,    0, 0, 0, 1, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[5]  = mk(1, 0,    6'h21,0,    0, 0, 0, 1, 0, 0,    0, 0,    0, 0, 0, 0);
        tbl[6]  = mk(1, 0,    6'h21,0,    0, 0, 0, 1, 0, 0,    1, 6'h21,0, 1, 0, 0);
        tbl[7]  = mk(0, 0,    0,    0,    0, 0, 0, 1, 1, 2,    0, 0,    0, 0, 1, 0);
        tbl[8]  = mk(1, 0,    0,    3,    1, 0, 1, 1, 0, 0,    0, 0,    0, 0, 1, 0);
        tbl[9]  = mk(1, 0,    0,    3,    0, 0, 1, 1, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[10] = mk(1, 0,    0,    4,    0, 0, 0, 0, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[11] = mk(1, 0,    0,    4,    0, 0, 0, 1, 0, 0,    0, 0,    0, 1, 0, 0);
        tbl[12] = mk(1, 0,    0,    4,    0, 0, 0, 1, 0, 0,    0, 0,    0, 0, 0, 0);
        tbl[13] = mk(0, 0,    0,    0,    0, 0, 0, 1, 1, 7,    0, 0,    0, 0, 0, 1);
        tbl[14] = mk(0, 0,    0,    0,    0, 0, 0, 1, 1, 4,    1, 4,    0, 0, 0, 1);
        tbl[15] = mk(0, 0,    0,    0,    0, 0, 0, 1, 1, 3,    0, 0,    0, 0, 1, 1);
        tbl[16] = mk(1, 0,    0,    8,    0, 0, 0, 1, 0, 0,    0, 0,    1, 0, 1, 1);
        tbl[17] = mk(1, 0,    0,    0,    0, 0, 0, 1, 1, 0,    0, 0,    0, 1, 1, 1);

        // Serial drain, then flush out of DRAIN.
        seq[0]  = mk(1, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        seq[1]  = mk(1, 0, 0, 2,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        seq[2]  = mk(1, 0, 0, 3,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        seq[3]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        seq[4]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0);
        seq[5]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 2, 0, 0,  0, 0, 0, 0);
        seq[6]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 1, 3, 0, 0,  0, 0, 1, 0);
        seq[7]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0);
        seq[8]  = mk(1, 0, 0, 9,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        seq[9]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        seq[10] = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0);
        seq[11] = mk(1, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        seq[12] = mk(1, 9, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        seq[13] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 9, 1, 10, 0, 0, 1, 0);
        seq[14] = mk(1, 11,0, 0,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0);

        dec_valid = 1;
        #2;
        check("reset.issue_valid", int'(issue_valid), 0);
        check("reset.inflight", int'(inflight), 0);
        check("reset.idle", int'(idle), 1);
        check("reset.sb_err", int'(sb_err), 0);
        dec_valid = 0;
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Mid-run async reset with busy bits set and sb_err sticky.
        apply(mk(1, 0, 0, 11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1), "pre_rst0");
        apply(mk(1, 0, 0, 12, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1), "pre_rst1");
        dec_valid = 1; dec_a_rs1 = 0; dec_a_rs2 = 0; dec_a_rd = 0;
        dec_serial = 0; dec_long = 0; wb0_valid = 0; wb1_valid = 0; flush = 0;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst.issue_valid", int'(issue_valid), 0);
        check("midrst.inflight", int'(inflight), 0);
        check("midrst.idle", int'(idle), 1);
        check("midrst.sb_err", int'(sb_err), 0);
        mb = '0;
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) apply(seq[i], $sformatf("seq%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
